// File: rtl/ccff_io_config_loader.sv
// IO tile configuration-chain loader: serialises bitstream words LSB first onto ccff_head.
// Optional tail check (all emerging bits must be 0) is compiled in with `define CCFF_TAIL_CHECK_EN.
module ccff_io_config_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              isol_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WB_W-1:0]   word_bit_q, word_bit_d;
   logic              head_q, head_d;
   logic              shift_en_q, shift_en_d;
   logic              isol_n_q, isol_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_d;

`ifdef CCFF_TAIL_CHECK_EN
   logic              error_q;
`endif

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      word_bit_d = word_bit_q;
`ifdef CCFF_TAIL_CHECK_EN
      error_d    = error_q;
      // Tail is sampled on the same cycles the chain is clocked.
      if (shift_en_q && ccff_tail) begin
         error_d = 1'b1;
      end
`else
      error_d    = 1'b0;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_FETCH;
               bit_cnt_d = '0;
               error_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            if (cfg_valid) begin
               shreg_d    = cfg_data;
               word_bit_d = '0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shreg_d    = shreg_q >> 1;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            word_bit_d = word_bit_q + WB_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               state_d = ST_DONE;
            end else if (word_bit_q == LAST_WBIT) begin
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so head/enable line up with SHIFT cycles.
      shift_en_d = (state_d == ST_SHIFT);
      head_d     = shift_en_d & shreg_d[0];
      busy_d     = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
      done_d     = (state_d == ST_DONE);
      isol_n_d   = (state_d == ST_DONE) && !error_d;
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         word_bit_q <= '0;
         head_q     <= 1'b0;
         shift_en_q <= 1'b0;
         isol_n_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         word_bit_q <= word_bit_d;
         head_q     <= head_d;
         shift_en_q <= shift_en_d;
         isol_n_q   <= isol_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef CCFF_TAIL_CHECK_EN
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail ^ error_d;
   assign error       = 1'b0;
`endif

   assign cfg_ready     = (state_q == ST_FETCH);
   assign ccff_head     = head_q;
   assign ccff_shift_en = shift_en_q;
   assign isol_n        = isol_n_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ccff_io_config_loader.sv
// Scoreboard bench: driver pushes the expected serial bitstream per accepted word,
// a negedge monitor pops one bit per ccff_shift_en pulse. Two instances: CHAIN_LEN 64 and 20.
module tb_ccff_io_config_loader;

   localparam int W  = 8;
   localparam int L0 = 64;
   localparam int L1 = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   rst, start, cfg_valid, cfg_ready, head, shen, tail;
   logic [1:0]   isol_n, busy, done, error;
   logic [W-1:0] cfg_data [2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_q0[$];
   bit exp_q1[$];
   int pulses [2] = '{0, 0};
   int tail_at = 0;

   ccff_io_config_loader #(.CHAIN_LEN(L0), .WORD_W(W), .CNT_W(16)) u_dut0 (
      .prog_clk(clk), .prog_reset(rst[0]), .start(start[0]),
      .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
      .ccff_head(head[0]), .ccff_shift_en(shen[0]), .ccff_tail(tail[0]),
      .isol_n(isol_n[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

   ccff_io_config_loader #(.CHAIN_LEN(L1), .WORD_W(W), .CNT_W(16)) u_dut1 (
      .prog_clk(clk), .prog_reset(rst[1]), .start(start[1]),
      .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
      .ccff_head(head[1]), .ccff_shift_en(shen[1]), .ccff_tail(tail[1]),
      .isol_n(isol_n[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected bit per enable pulse, in push order.
   always @(negedge clk) begin
      bit e;
      if (shen[0] === 1'b1) begin
         pulses[0]++;
         if (exp_q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL head0_extra_pulse: got pulse %0d expected none", pulses[0]);
         end else begin
            e = exp_q0.pop_front();
            check("head0", head[0], e);
         end
      end
      if (shen[1] === 1'b1) begin
         pulses[1]++;
         if (exp_q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL head1_extra_pulse: got pulse %0d expected none", pulses[1]);
         end else begin
            e = exp_q1.pop_front();
            check("head1", head[1], e);
         end
      end
      tail[0] = (tail_at != 0) && (shen[0] === 1'b1) && (pulses[0] == tail_at);
      tail[1] = 1'b0;
   end

   task automatic push_bit(input int idx, input bit b);
      if (idx == 0) exp_q0.push_back(b);
      else          exp_q1.push_back(b);
   endtask

   function automatic int qsize(input int idx);
      return (idx == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // One load: start, feed words (optional forced stall, random gaps, optional mid-load reset).
   task automatic load(input int idx, input int len, input int stall_word, input int stall_len,
                       input bit seq_data, input int gap_pct, input int abort_bit, input bit exp_err);
      int w = 0, pushed = 0, gaps = 0, stalled = 0, t0, p0, words, guard;
      bit rdy, v, seen;
      logic [W-1:0] d;
      words = (len + W - 1) / W;
      p0 = pulses[idx];
      @(negedge clk); #1;
      start[idx] = 1'b1;
      t0 = cyc;
      @(negedge clk); #1;
      start[idx] = 1'b0;
      check("busy_at_t1", busy[idx], 1);
      check("ready_at_t1", cfg_ready[idx], 1);
      check("error_cleared", error[idx], 0);
      check("isol_low_loading", isol_n[idx], 0);
      guard = 0;
      while (pushed < len && guard < 3000) begin
         guard++;
         if (abort_bit > 0 && pulses[idx] - p0 >= abort_bit) begin
            rst[idx] = 1'b1;
            cfg_valid[idx] = 1'b0;
            @(negedge clk); #1;
            check("abort_isol_n", isol_n[idx], 0);
            check("abort_busy", busy[idx], 0);
            check("abort_ready", cfg_ready[idx], 0);
            check("abort_shen", shen[idx], 0);
            check("abort_done", done[idx], 0);
            rst[idx] = 1'b0;
            if (idx == 0) exp_q0.delete(); else exp_q1.delete();
            return;
         end
         rdy = cfg_ready[idx];
         if (rdy && w == stall_word && stalled < stall_len) begin
            v = 1'b0;
            stalled++;
            check("stall_shen", shen[idx], 0);
         end else begin
            v = ($urandom_range(99) >= gap_pct);
         end
         if (rdy && !v) gaps++;
         d = seq_data ? W'(w + 1) : W'($urandom);
         cfg_valid[idx] = v;
         cfg_data[idx]  = d;
         if (rdy && v) begin
            for (int b = 0; b < W; b++) begin
               if (pushed < len) begin
                  push_bit(idx, d[b]);
                  pushed++;
               end
            end
            w++;
         end
         @(negedge clk); #1;
      end
      if (pushed < len) begin
         n_cmp++; n_bad++;
         $display("FAIL feed_timeout: got %0d bits accepted expected %0d", pushed, len);
      end
      cfg_valid[idx] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin
         if (done[idx] === 1'b1) seen = 1'b1;
         else begin
            check("no_extra_ready", cfg_ready[idx], 0);
            @(negedge clk); #1;
         end
      end
      check("done_seen", seen, 1);
      check("done_latency", cyc - t0, words + len + 1 + gaps);
      check("done_isol_n", isol_n[idx], exp_err ? 0 : 1);
      check("done_busy", busy[idx], 0);
      check("done_error", error[idx], exp_err);
      check("pulse_count", pulses[idx] - p0, len);
      check("queue_drained", qsize(idx), 0);
      repeat (3) begin
         @(negedge clk); #1;
         check("idle_ready_after_done", cfg_ready[idx], 0);
         check("done_held", done[idx], 1);
      end
      cfg_valid[idx] = 1'b0;
   endtask

   initial begin
      rst = 2'b11;
      start = 2'b00;
      cfg_valid = 2'b00;
      cfg_data[0] = '0;
      cfg_data[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", cfg_ready[i], 0);
         check("rst_head", head[i], 0);
         check("rst_shen", shen[i], 0);
         check("rst_isol_n", isol_n[i], 0);
         check("rst_busy", busy[i], 0);
         check("rst_done", done[i], 0);
         check("rst_error", error[i], 0);
      end
      rst = 2'b00;
      cfg_valid = 2'b11;
      repeat (10) begin
         @(negedge clk); #1;
         check("idle_ready0", cfg_ready[0], 0);
         check("idle_ready1", cfg_ready[1], 0);
         check("idle_busy0", busy[0], 0);
      end
      cfg_valid = 2'b00;

      load(0, L0, -1, 0, 1'b1, 0, 0, 1'b0);
      load(0, L0, 3, 5, 1'b0, 0, 0, 1'b0);
      load(0, L0, -1, 0, 1'b0, 30, 0, 1'b0);
      load(1, L1, -1, 0, 1'b0, 0, 0, 1'b0);
      load(1, L1, -1, 0, 1'b0, 25, 0, 1'b0);
      load(0, L0, -1, 0, 1'b0, 0, 30, 1'b0);
      load(0, L0, -1, 0, 1'b0, 0, 0, 1'b0);
`ifdef CCFF_TAIL_CHECK_EN
      tail_at = pulses[0] + 10;
      load(0, L0, -1, 0, 1'b0, 0, 0, 1'b1);
      tail_at = 0;
      load(0, L0, -1, 0, 1'b0, 10, 0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
